core_flow_ctrl: RTL and testbench
=================================

Name: core_flow_ctrl

Overview:
- Pipeline flow controller for the core; sits beside the PC generator.
- Sole driver of the PC generator's reset_flag, hold_flag, jump_flag and jump_addr.
- Arbitrates redirect sources (interrupt unit, execute-stage branch/jump), merges stall sources (bus, multi-cycle divider), sequences debug-requested software reset.
- Generates pipeline flush to the IF/ID and ID/EX registers.

Parameters:
- DATA_W, `DATA_BUS_WIDTH (32), address/data width.
- RESET_CYCLES, 4, cycles reset_flag_o is held during a software reset (1..15).
- FLUSH_CYCLES, 2, cycles flush_o stays high after any redirect (1..3).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous active-high reset.
- ex_jump_req_i  in  1  execute-stage taken branch/jump, single-cycle pulse.
- ex_jump_addr_i  in  DATA_W  target for ex_jump_req_i.
- int_req_i  in  1  interrupt request; level, held until int_ack_o.
- int_addr_i  in  DATA_W  trap vector, sampled in the ack cycle.
- int_ack_o  out  1  one-cycle pulse: interrupt redirect issued this cycle.
- bus_stall_i  in  1  instruction/data bus not ready.
- div_busy_i  in  1  multi-cycle divider in progress.
- dbg_reset_req_i  in  1  debug software-reset request, level; acted on at rising edge.
- reset_flag_o  out  1  to PC generator: load reset PC.
- hold_flag_o  out  1  to PC generator and pipeline regs: freeze.
- jump_flag_o  out  1  to PC generator: load jump_addr_o.
- jump_addr_o  out  DATA_W  redirect target.
- flush_o  out  1  squash IF/ID and ID/EX contents.

Behaviour:
- States: RUN, INT_WAIT, SWRST. Registered: state, rst counter (4 b), flush counter (2 b), dbg_reset_req_i delay flop.
- Reset (rst_i high, async): state RUN, counters 0, edge flop 0. All outputs 0, jump_addr_o 0.
- blocked = bus_stall_i | div_busy_i.
- dbg_rise = dbg_reset_req_i & ~dbg_q.
- jump_flag_o, jump_addr_o, int_ack_o and hold_flag_o are combinational from inputs and state. The redirect reaches the PC generator in the same cycle, so the PC updates on the next edge.
- reset_flag_o and flush_o are registered-state decodes.
- RUN priority, highest first:
  - (1) dbg_rise: go to SWRST, load rst counter with RESET_CYCLES; no jump this cycle.
  - (2) int_req_i & ~blocked: jump_flag_o=1, jump_addr_o=int_addr_i, int_ack_o=1, start flush; any simultaneous ex_jump_req_i is discarded.
  - (3) int_req_i & blocked: go to INT_WAIT. ex_jump_req_i is still honoured this cycle (jump_flag_o=1, ex target).
  - (4) ex_jump_req_i: jump_flag_o=1, jump_addr_o=ex_jump_addr_i, start flush.
  - (5) hold_flag_o=blocked.
- INT_WAIT:
  - hold_flag_o=1 always (no new fetch).
  - ex_jump_req_i still redirects (in-flight instruction retires), with flush.
  - When ~blocked: issue interrupt redirect and ack as in RUN (2), but only if no ex_jump_req_i that cycle; otherwise issue the ex redirect and stay in INT_WAIT. Return to RUN after the ack.
  - int_req_i deasserting before ack: return to RUN, no ack.
  - dbg_rise: go to SWRST; pending interrupt dropped without ack.
- SWRST:
  - reset_flag_o=1, flush_o=1, hold_flag_o=1, jump_flag_o=0, int_ack_o=0.
  - Counter decrements each cycle; at 1 go to RUN. reset_flag_o is high exactly RESET_CYCLES cycles.
  - All requests ignored; a further dbg_rise is ignored; int_req_i is re-evaluated in RUN.
- Flush counter:
  - Loaded with FLUSH_CYCLES on every redirect edge; flush_o = counter != 0.
  - Decrements only when hold_flag_o=0, so flush survives stalls.
  - A redirect while the counter is nonzero reloads it.
- jump_addr_o is 0 whenever jump_flag_o=0.
- Never assert jump_flag_o and reset_flag_o together.

Decomposition:
- Shared chip param package: DATA_BUS_WIDTH, the state encodings (RUN=2'd0, INT_WAIT=2'd1, SWRST=2'd2) and default RESET_CYCLES/FLUSH_CYCLES.
- No sub-module needed. Optional core_flow_cnt: down-counter with load/enable, instantiated twice (reset, flush).

Test Plan:
- rst_i high mid-SWRST (counter=2) -> all outputs 0 immediately. After release: RUN, ex_jump_req_i with 0x80 -> jump_flag_o=1, jump_addr_o=0x80 same cycle.
- ex_jump_req_i with 0x100, no stall -> jump_flag_o 1 cycle. flush_o high the next 2 cycles. With bus_stall_i high for 3 cycles during the flush -> flush_o stays high 5 cycles total.
- int_req_i and ex_jump_req_i together, unblocked, int_addr_i=0x200 -> jump_addr_o=0x200, int_ack_o=1, ex target dropped.
- int_req_i while div_busy_i high 4 cycles -> INT_WAIT, hold_flag_o=1. Ack in the cycle div_busy_i falls, jump_addr_o=int_addr_i. An ex jump to 0x300 during the wait is issued first.
- dbg_reset_req_i rising while in INT_WAIT -> reset_flag_o high exactly 4 cycles, int_ack_o never pulses. Holding dbg_reset_req_i high afterward triggers no second reset.
- int_req_i dropped during INT_WAIT -> return to RUN, no int_ack_o, hold_flag_o follows blocked.

Source files
------------

// File: rtl/core_flow_ctrl_pkg.sv
// ============================================================================
// Module   : core_flow_ctrl_pkg
// Purpose  : Shared chip parameters and flow-controller state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_flow_ctrl_pkg;

    localparam int DATA_BUS_WIDTH   = 32;
    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        INT_WAIT = 2'd1,
        SWRST    = 2'd2
    } flow_state_e;

endpackage

`default_nettype wire

// File: rtl/core_flow_cnt.sv
// ============================================================================
// Module   : core_flow_cnt
// Purpose  : Saturating down-counter with synchronous load and decrement enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_flow_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    // Load wins over decrement; the count stops at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/core_flow_ctrl.sv
// ============================================================================
// Module   : core_flow_ctrl
// Purpose  : Pipeline flow controller: redirect arbitration, stall merge,
//            debug software-reset sequencing and pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_flow_ctrl
    import core_flow_ctrl_pkg::*;
#(
    parameter int DATA_W       = DATA_BUS_WIDTH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_jump_req_i,
    input  logic [DATA_W-1:0] ex_jump_addr_i,
    input  logic              int_req_i,
    input  logic [DATA_W-1:0] int_addr_i,
    output logic              int_ack_o,
    input  logic              bus_stall_i,
    input  logic              div_busy_i,
    input  logic              dbg_reset_req_i,
    output logic              reset_flag_o,
    output logic              hold_flag_o,
    output logic              jump_flag_o,
    output logic [DATA_W-1:0] jump_addr_o,
    output logic              flush_o
);

    flow_state_e r_state;
    flow_state_e w_next_state;
    logic        r_dbg_q;
    logic [3:0]  w_rst_cnt;
    logic [1:0]  w_flush_cnt;
    logic        w_blocked;
    logic        w_dbg_rise;
    logic        w_rst_load;

    assign w_blocked  = bus_stall_i | div_busy_i;
    assign w_dbg_rise = dbg_reset_req_i & ~r_dbg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_dbg_q <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dbg_q <= dbg_reset_req_i;
        end
    end

    always_comb begin
        w_next_state = r_state;
        jump_flag_o  = 1'b0;
        jump_addr_o  = '0;
        int_ack_o    = 1'b0;
        hold_flag_o  = 1'b0;
        w_rst_load   = 1'b0;
        case (r_state)
            RUN: begin
                hold_flag_o = w_blocked;
                if (w_dbg_rise) begin
                    w_next_state = SWRST;
                    w_rst_load   = 1'b1;
                end else if (int_req_i && !w_blocked) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = int_addr_i;
                    int_ack_o   = 1'b1;
                end else begin
                    if (int_req_i) begin
                        w_next_state = INT_WAIT;
                    end
                    if (ex_jump_req_i) begin
                        jump_flag_o = 1'b1;
                        jump_addr_o = ex_jump_addr_i;
                    end
                end
            end
            INT_WAIT: begin
                hold_flag_o = 1'b1;
                if (w_dbg_rise) begin
                    w_next_state = SWRST;
                    w_rst_load   = 1'b1;
                end else if (ex_jump_req_i) begin
                    // The in-flight instruction's redirect goes ahead of the trap.
                    jump_flag_o = 1'b1;
                    jump_addr_o = ex_jump_addr_i;
                    if (!int_req_i) begin
                        w_next_state = RUN;
                    end
                end else if (!int_req_i) begin
                    w_next_state = RUN;
                end else if (!w_blocked) begin
                    jump_flag_o  = 1'b1;
                    jump_addr_o  = int_addr_i;
                    int_ack_o    = 1'b1;
                    w_next_state = RUN;
                end
            end
            SWRST: begin
                hold_flag_o = 1'b1;
                if (w_rst_cnt <= 4'd1) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    core_flow_cnt #(.WIDTH(4)) u_rst_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_rst_load),
        .load_val_i (4'(RESET_CYCLES)),
        .dec_i      (r_state == SWRST),
        .count_o    (w_rst_cnt)
    );

    // Only counts down while the pipeline advances, so a flush outlives stalls.
    core_flow_cnt #(.WIDTH(2)) u_flush_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (jump_flag_o),
        .load_val_i (2'(FLUSH_CYCLES)),
        .dec_i      (~hold_flag_o),
        .count_o    (w_flush_cnt)
    );

    assign reset_flag_o = (r_state == SWRST);
    assign flush_o      = (r_state == SWRST) || (w_flush_cnt != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_core_flow_ctrl.sv
// ============================================================================
// Module   : tb_core_flow_ctrl
// Purpose  : Directed self-checking bench for core_flow_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic        int_req;
    logic [31:0] int_addr;
    logic        int_ack;
    logic        bus_stall;
    logic        div_busy;
    logic        dbg_reset_req;
    logic        reset_flag;
    logic        hold_flag;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        flush;
    logic [4:0]  obs;

    int n_checks = 0;
    int n_fail   = 0;

    core_flow_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ex_jump_req_i   (ex_jump_req),
        .ex_jump_addr_i  (ex_jump_addr),
        .int_req_i       (int_req),
        .int_addr_i      (int_addr),
        .int_ack_o       (int_ack),
        .bus_stall_i     (bus_stall),
        .div_busy_i      (div_busy),
        .dbg_reset_req_i (dbg_reset_req),
        .reset_flag_o    (reset_flag),
        .hold_flag_o     (hold_flag),
        .jump_flag_o     (jump_flag),
        .jump_addr_o     (jump_addr),
        .flush_o         (flush)
    );

    always #5 clk = ~clk;

    // Flag order: {reset_flag, hold_flag, jump_flag, int_ack, flush}
    assign obs = {reset_flag, hold_flag, jump_flag, int_ack, flush};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (obs !== 5'b00000 || jump_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: flags=%b addr=%h, expected flags=00000 addr=0", obs, jump_addr);
        end
        rst = 1'b0;
        tick();
        dbg_reset_req = 1'b1;
        repeat (3) tick();
        #1;
        n_checks++;
        if (obs !== 5'b11001) begin
            n_fail++;
            $display("FAIL swrst_active: flags=%b, expected 11001", obs);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 5'b00000 || jump_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_mid_swrst: flags=%b addr=%h, expected flags=00000 addr=0", obs, jump_addr);
        end
        dbg_reset_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        ex_jump_req  = 1'b1;
        ex_jump_addr = 32'h80;
        #1;
        n_checks++;
        if (obs !== 5'b00100 || jump_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL post_reset_jump: flags=%b addr=%h, expected flags=00100 addr=80", obs, jump_addr);
        end
        tick();
        ex_jump_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        logic [4:0] exp_plain [4];
        logic [4:0] exp_stall [6];
        exp_plain = '{5'b00100, 5'b00001, 5'b00001, 5'b00000};
        exp_stall = '{5'b00001, 5'b01001, 5'b01001, 5'b01001, 5'b00001, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            tick();
            ex_jump_req  = (i == 0);
            ex_jump_addr = 32'h100;
            #1;
            n_checks++;
            if (obs !== exp_plain[i] || jump_addr !== ((i == 0) ? 32'h100 : 32'h0)) begin
                n_fail++;
                $display("FAIL flush_plain[%0d]: flags=%b addr=%h, expected flags=%b", i, obs, jump_addr, exp_plain[i]);
            end
        end
        tick();
        ex_jump_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ex_jump_req = 1'b0;
            bus_stall   = (i >= 1 && i <= 3);
            #1;
            n_checks++;
            if (obs !== exp_stall[i]) begin
                n_fail++;
                $display("FAIL flush_stall[%0d]: flags=%b, expected %b", i, obs, exp_stall[i]);
            end
        end
    endtask

    task automatic test_int_priority();
        tick();
        int_req      = 1'b1;
        ex_jump_req  = 1'b1;
        ex_jump_addr = 32'h180;
        int_addr     = 32'h200;
        #1;
        n_checks++;
        if (obs !== 5'b00110 || jump_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL int_over_ex: flags=%b addr=%h, expected flags=00110 addr=200", obs, jump_addr);
        end
        tick();
        int_req     = 1'b0;
        ex_jump_req = 1'b0;
        #1;
        n_checks++;
        if (obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL int_flush: flags=%b, expected 00001", obs);
        end
        repeat (3) tick();
    endtask

    task automatic test_int_wait();
        logic [4:0]  exp_f [8];
        logic [31:0] exp_a [8];
        exp_f = '{5'b01000, 5'b01100, 5'b01001, 5'b01001, 5'b01111, 5'b00001, 5'b00001, 5'b00000};
        exp_a = '{32'h0, 32'h300, 32'h0, 32'h0, 32'h400, 32'h0, 32'h0, 32'h0};
        int_addr     = 32'h400;
        ex_jump_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            tick();
            div_busy    = (i <= 3);
            int_req     = (i <= 4);
            ex_jump_req = (i == 1);
            #1;
            n_checks++;
            if (obs !== exp_f[i] || jump_addr !== exp_a[i]) begin
                n_fail++;
                $display("FAIL int_wait[%0d]: flags=%b addr=%h, expected flags=%b addr=%h", i, obs, jump_addr, exp_f[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_dbg_in_wait();
        logic [4:0] exp_f [11];
        exp_f = '{5'b01000, 5'b01000, 5'b01000, 5'b11001, 5'b11001, 5'b11001, 5'b11001,
                  5'b01000, 5'b01000, 5'b01000, 5'b01000};
        int_addr = 32'h500;
        for (int i = 0; i < 11; i++) begin
            tick();
            bus_stall     = 1'b1;
            int_req       = (i <= 8);
            dbg_reset_req = (i >= 2);
            #1;
            n_checks++;
            if (obs !== exp_f[i] || jump_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL dbg_wait[%0d]: flags=%b addr=%h, expected flags=%b addr=0", i, obs, jump_addr, exp_f[i]);
            end
        end
        bus_stall = 1'b0;
        #1;
        n_checks++;
        if (obs !== 5'b00000) begin
            n_fail++;
            $display("FAIL hold_follows_blocked: flags=%b, expected 00000", obs);
        end
        dbg_reset_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        rst           = 1'b1;
        ex_jump_req   = 1'b0;
        ex_jump_addr  = 32'h0;
        int_req       = 1'b0;
        int_addr      = 32'h0;
        bus_stall     = 1'b0;
        div_busy      = 1'b0;
        dbg_reset_req = 1'b0;
        test_reset();
        test_flush();
        test_int_priority();
        test_int_wait();
        test_dbg_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
